// File: rtl/hvsync_timing_gen.sv
// Free-running raster timing generator: pixel/line counters, sync pulses, display-active flag.
// Latency: sync/display decode is combinational from hpos/vpos (zero cycles). No backpressure; counters free-run.
module hvsync_timing_gen #(
  parameter int H_DISPLAY = 256,
  parameter int H_FRONT   = 7,
  parameter int H_SYNC    = 23,
  parameter int H_BACK    = 23,
  parameter int V_DISPLAY = 240,
  parameter int V_BOTTOM  = 14,
  parameter int V_SYNC    = 3,
  parameter int V_TOP     = 5,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [8:0] hpos,
  output logic [8:0] vpos
);

  localparam int H_MAX_I    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int HS_START_I = H_DISPLAY + H_FRONT;
  localparam int HS_END_I   = HS_START_I + H_SYNC - 1;
  localparam int V_MAX_I    = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP - 1;
  localparam int VS_START_I = V_DISPLAY + V_BOTTOM;
  localparam int VS_END_I   = VS_START_I + V_SYNC - 1;

  // Counters are 9 bits wide, so any timing whose extent exceeds 511 cannot be represented.
  if (H_MAX_I > 511 || V_MAX_I > 511) begin : g_bad_timing
    $error("hvsync_timing_gen: H_MAX (%0d) and V_MAX (%0d) must be at most 511", H_MAX_I, V_MAX_I);
  end

  localparam logic [8:0] H_MAX    = 9'(H_MAX_I);
  localparam logic [8:0] HS_START = 9'(HS_START_I);
  localparam logic [8:0] HS_END   = 9'(HS_END_I);
  localparam logic [8:0] H_DISP   = 9'(H_DISPLAY);
  localparam logic [8:0] V_MAX    = 9'(V_MAX_I);
  localparam logic [8:0] VS_START = 9'(VS_START_I);
  localparam logic [8:0] VS_END   = 9'(VS_END_I);
  localparam logic [8:0] V_DISP   = 9'(V_DISPLAY);

  logic h_end;
  logic v_end;
  logic hs_act;
  logic vs_act;

  assign h_end = (hpos == H_MAX);
  assign v_end = (vpos == V_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      hpos <= '0;
      vpos <= '0;
    end else begin
      hpos <= h_end ? '0 : hpos + 9'd1;
      // The line counter only moves on the last pixel of a line.
      if (h_end) begin
        vpos <= v_end ? '0 : vpos + 9'd1;
      end
    end
  end

  always_comb begin
    hs_act     = (hpos >= HS_START) && (hpos <= HS_END);
    vs_act     = (vpos >= VS_START) && (vpos <= VS_END);
    hsync      = HSYNC_POL ? hs_act : ~hs_act;
    vsync      = VSYNC_POL ? vs_act : ~vs_act;
    display_on = (hpos < H_DISP) && (vpos < V_DISP);
  end

endmodule

// File: tb/tb_hvsync_timing_gen.sv
// Randomized-reset bench: three generators (two default, one inverted polarity) checked every cycle
// against an arithmetic model that derives (hpos, vpos) from the clock count since the last reset.
module tb_hvsync_timing_gen;

  localparam int HT    = 309;
  localparam int VT    = 262;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rst_c;
  logic       hs_a, vs_a, de_a, hs_b, vs_b, de_b, hs_c, vs_c, de_c;
  logic [8:0] hp_a, vp_a, hp_b, vp_b, hp_c, vp_c;

  hvsync_timing_gen u_dut_a (
    .clk(clk), .reset(rst_a), .hsync(hs_a), .vsync(vs_a),
    .display_on(de_a), .hpos(hp_a), .vpos(vp_a)
  );

  hvsync_timing_gen u_dut_b (
    .clk(clk), .reset(rst_b), .hsync(hs_b), .vsync(vs_b),
    .display_on(de_b), .hpos(hp_b), .vpos(vp_b)
  );

  hvsync_timing_gen #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_dut_c (
    .clk(clk), .reset(rst_c), .hsync(hs_c), .vsync(vs_c),
    .display_on(de_c), .hpos(hp_c), .vpos(vp_c)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d", tag, obs, obs, exp);
    end
  endtask

  // Expected raster state is pure arithmetic on the number of clocks since reset.
  task automatic check_dut(input string p, input int t, input bit pol,
                           input logic [8:0] hp, input logic [8:0] vp,
                           input logic hs, input logic vs, input logic de);
    int h, v;
    bit hs_on, vs_on, de_exp;
    h      = t % HT;
    v      = (t / HT) % VT;
    hs_on  = (h >= 263) && (h <= 285);
    vs_on  = (v >= 254) && (v <= 256);
    de_exp = (h < 256) && (v < 240);
    check_eq({p, "_hpos"}, {23'b0, hp}, h);
    check_eq({p, "_vpos"}, {23'b0, vp}, v);
    check_eq({p, "_hsync"}, {31'b0, hs}, {31'b0, (pol ? hs_on : !hs_on)});
    check_eq({p, "_vsync"}, {31'b0, vs}, {31'b0, (pol ? vs_on : !vs_on)});
    check_eq({p, "_display_on"}, {31'b0, de}, {31'b0, de_exp});
  endtask

  int t_a, t_b, t_c;
  bit v_a, v_b, v_c;
  int hold_a, hold_b, hold_c;
  bit mid_done, mid_pending;
  bit prev_hs_a, prev_vs_a;
  int hs_rises, vs_rises;

  initial begin
    t_a = 0; t_b = 0; t_c = 0;
    v_a = 0; v_b = 0; v_c = 0;
    mid_done = 0; mid_pending = 0;
    prev_hs_a = 0; prev_vs_a = 0;
    hs_rises = 0; vs_rises = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    hold_a = $urandom_range(0, 3);
    hold_b = $urandom_range(0, 3);
    hold_c = $urandom_range(0, 3);

    for (int cyc = 0; cyc < FRAME + 300; cyc++) begin
      @(posedge clk);
      if (rst_a) begin t_a = 0; v_a = 1; end else t_a++;
      if (rst_b) begin t_b = 0; v_b = 1; end else t_b++;
      if (rst_c) begin t_c = 0; v_c = 1; end else t_c++;

      @(negedge clk);
      if (v_a) check_dut("a", t_a, 1'b1, hp_a, vp_a, hs_a, vs_a, de_a);
      if (v_b) check_dut("b", t_b, 1'b1, hp_b, vp_b, hs_b, vs_b, de_b);
      if (v_c) check_dut("c", t_c, 1'b0, hp_c, vp_c, hs_c, vs_c, de_c);

      // One full frame of A after reset: count sync rising edges.
      if (v_a && t_a > 0 && t_a < FRAME) begin
        if (hs_a && !prev_hs_a) hs_rises++;
        if (vs_a && !prev_vs_a) vs_rises++;
      end
      prev_hs_a = hs_a;
      prev_vs_a = vs_a;
      if (v_a && t_a == FRAME) begin
        check_eq("a_frame_wrap_hpos", {23'b0, hp_a}, 0);
        check_eq("a_frame_wrap_vpos", {23'b0, vp_a}, 0);
      end

      if (mid_pending) begin
        mid_pending = 0;
        check_eq("b_mid_reset_hpos", {23'b0, hp_b}, 0);
        check_eq("b_mid_reset_vpos", {23'b0, vp_b}, 0);
        check_eq("b_mid_reset_hsync", {31'b0, hs_b}, 0);
        check_eq("b_mid_reset_vsync", {31'b0, vs_b}, 0);
        check_eq("b_mid_reset_display_on", {31'b0, de_b}, 1);
      end

      // Next-cycle reset decisions.
      rst_a = 1'b0;
      if (hold_a > 0) begin rst_a = 1'b1; hold_a--; end

      rst_b = 1'b0;
      if (hold_b > 0) begin
        rst_b = 1'b1; hold_b--;
      end else if (!mid_done && v_b && (t_b % HT) == 150 && ((t_b / HT) % VT) == 100) begin
        rst_b = 1'b1; mid_done = 1; mid_pending = 1;
      end else if (mid_done && $urandom_range(0, 2999) == 0) begin
        rst_b = 1'b1; hold_b = $urandom_range(0, 2);
      end

      rst_c = 1'b0;
      if (hold_c > 0) begin
        rst_c = 1'b1; hold_c--;
      end else if ($urandom_range(0, 2499) == 0) begin
        rst_c = 1'b1; hold_c = $urandom_range(0, 4);
      end
    end

    check_eq("a_hsync_rises_per_frame", hs_rises, 262);
    check_eq("a_vsync_rises_per_frame", vs_rises, 1);
    check_eq("b_mid_reset_reached", {31'b0, mid_done}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hvsync_timing_gen.md
Name: hvsync_timing_gen

Overview:
- Free-running raster timing generator for the video path.
- Produces horizontal and vertical pixel counters, sync pulses and a display-active flag.
- Sprite and playfield renderers compare against `hpos`/`vpos` to position graphics.
- Sprite logic advances its line counter on each rising edge of `hsync`.
- Default timing is the 256x240 low-resolution mode: 309 clocks per line, 262 lines per frame. One clock equals one pixel.

Parameters:
- H_DISPLAY, 256, visible pixels per line
- H_FRONT, 7, right border / front porch clocks
- H_SYNC, 23, hsync pulse width in clocks
- H_BACK, 23, left border / back porch clocks
- V_DISPLAY, 240, visible lines per frame
- V_BOTTOM, 14, bottom border lines
- V_SYNC, 3, vsync pulse width in lines
- V_TOP, 5, top border lines
- HSYNC_POL, 1, active level of hsync (1 = active-high)
- VSYNC_POL, 1, active level of vsync (1 = active-high)

Ports:
- clk  input  1  pixel clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- hsync  output  1  horizontal sync, asserted at HSYNC_POL during the sync window
- vsync  output  1  vertical sync, asserted at VSYNC_POL during the sync window
- display_on  output  1  high while (hpos, vpos) lies in the visible area
- hpos  output  9  current horizontal pixel position, 0..H_MAX
- vpos  output  9  current line number, 0..V_MAX

Behaviour:
- Derived constants:
  - H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1 (default 308)
  - HS_START = H_DISPLAY+H_FRONT (263)
  - HS_END = HS_START+H_SYNC-1 (285)
  - V_MAX = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP-1 (261)
  - VS_START = V_DISPLAY+V_BOTTOM (254)
  - VS_END = VS_START+V_SYNC-1 (256)
- Both H_MAX and V_MAX must be at most 511. Parameter sets violating this are illegal; a simulation-time check issues an error.
- hpos and vpos are registers.
- Reset: on a clock edge with reset=1, hpos<=0 and vpos<=0. Reset overrides counting and may arrive mid-line or mid-frame.
- Outputs during reset cycles follow the decode below from the zeroed counters: display_on=1, hsync and vsync inactive.
- Horizontal counter: each clock, hpos increments by 1. When hpos==H_MAX it wraps to 0 on the next clock.
- Vertical counter: vpos changes only on the clock where hpos wraps (hpos==H_MAX).
  - If vpos==V_MAX, vpos wraps to 0.
  - Otherwise vpos increments by 1.
- hpos and vpos never exceed H_MAX and V_MAX.
- Decode is combinational from the current counter registers, with zero latency relative to hpos/vpos:
  - hsync active iff HS_START <= hpos <= HS_END.
  - vsync active iff VS_START <= vpos <= VS_END. It spans whole lines, from hpos=0 of line VS_START through hpos=H_MAX of line VS_END.
  - display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- hsync pulses on every line, including vertical blanking lines.
- The rising edge of hsync (active-high) occurs exactly once per line, when hpos becomes HS_START.
- Frame period = (H_MAX+1)*(V_MAX+1) clocks; default 80958.
- No other inputs; there is no enable, so the counters free-run whenever reset is low.

Test Plan:
- Reset then run: after reset deasserts, hpos counts 0,1,2,...; at hpos=308 the next clock gives hpos=0, vpos=1. Check display_on=1 for hpos 0..255 on line 0 and 0 for hpos 256..308.
- hsync window: on any line, hsync=0 at hpos=262, 1 at hpos=263 through 285, 0 at 286. Count exactly 262 rising edges of hsync per 80958 clocks.
- vsync window: vsync=0 throughout line 253, 1 from (hpos=0, vpos=254) through (hpos=308, vpos=256), 0 at (0, 257).
- Frame wrap: at (hpos=308, vpos=261) the next clock gives (0, 0). display_on=0 for all of vpos 240..261. Frame length is exactly 80958 clocks between successive vsync rising edges.
- Mid-frame reset: assert reset for 1 clock at (hpos=150, vpos=100) -> next cycle hpos=0, vpos=0, hsync=0, vsync=0, display_on=1. Counting resumes normally.
- Polarity: with HSYNC_POL=0 and VSYNC_POL=0, hsync=0 only for hpos 263..285 and vsync=0 only for vpos 254..256. All else matches the default behaviour.
